// File: rtl/bolme_denetleyici.sv
// bolme_denetleyici: sequencer between execute and the shared divider
// with a one-entry result cache and flush absorption.
module bolme_denetleyici (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        islem_gecerli_i,
  input  logic [1:0]  islem_i,
  input  logic [31:0] bolunen_i,
  input  logic [31:0] bolen_i,
  input  logic        iptal_i,
  output logic [31:0] sonuc_o,
  output logic        sonuc_gecerli_o,
  output logic        mesgul_o,
  output logic        bolme_istek_o,
  output logic        bolme_sign_o,
  output logic [31:0] bolme_bolunen_o,
  output logic [31:0] bolme_bolen_o,
  input  logic [31:0] bolme_bolum_i,
  input  logic [31:0] bolme_kalan_i,
  input  logic        bolme_hazir_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  durum_q;
  logic [1:0]  durum_d;
  logic        iptal_q;
  logic        kalan_sec_q;
  logic [31:0] sonuc_q;
  logic        sign_q;
  logic [31:0] bolunen_q;
  logic [31:0] bolen_q;

  logic        ob_gecerli_q;
  logic        ob_sign_q;
  logic [31:0] ob_bolunen_q;
  logic [31:0] ob_bolen_q;
  logic [31:0] ob_bolum_q;
  logic [31:0] ob_kalan_q;

  logic istek_sign;
  logic isabet;
  logic kabul;
  logic oldur;
  logic bitti;

  assign istek_sign = ~islem_i[0];
  assign isabet = ob_gecerli_q
                & (ob_bolunen_q == bolunen_i)
                & (ob_bolen_q == bolen_i)
                & (ob_sign_q == istek_sign);
  assign kabul = (durum_q == S_IDLE)
               & islem_gecerli_i & ~iptal_i;
  assign oldur = iptal_q | iptal_i;
  assign bitti = (durum_q == S_WAIT) & bolme_hazir_i;

  always_comb begin
    durum_d = durum_q;
    unique case (durum_q)
      S_IDLE: begin
        if (kabul) durum_d = isabet ? S_DONE : S_ISSUE;
      end
      S_ISSUE: durum_d = S_WAIT;
      S_WAIT: begin
        if (bolme_hazir_i) durum_d = oldur ? S_IDLE : S_DONE;
      end
      S_DONE: durum_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q <= S_IDLE;
    end else begin
      durum_q <= durum_d;
    end
  end

  // Kill survives until the divider finishes; it cannot be aborted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      iptal_q <= 1'b0;
    end else if (bitti) begin
      iptal_q <= 1'b0;
    end else if (iptal_i && ((durum_q == S_ISSUE) || (durum_q == S_WAIT))) begin
      iptal_q <= 1'b1;
    end
  end

  // Divider-facing operands only move on a fresh miss in IDLE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sign_q      <= 1'b0;
      bolunen_q   <= '0;
      bolen_q     <= '0;
      kalan_sec_q <= 1'b0;
    end else if (kabul && !isabet) begin
      sign_q      <= istek_sign;
      bolunen_q   <= bolunen_i;
      bolen_q     <= bolen_i;
      kalan_sec_q <= islem_i[1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ob_gecerli_q <= 1'b0;
      ob_sign_q    <= 1'b0;
      ob_bolunen_q <= '0;
      ob_bolen_q   <= '0;
      ob_bolum_q   <= '0;
      ob_kalan_q   <= '0;
    end else if (bitti) begin
      ob_gecerli_q <= 1'b1;
      ob_sign_q    <= sign_q;
      ob_bolunen_q <= bolunen_q;
      ob_bolen_q   <= bolen_q;
      ob_bolum_q   <= bolme_bolum_i;
      ob_kalan_q   <= bolme_kalan_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sonuc_q <= '0;
    end else if (kabul && isabet) begin
      sonuc_q <= islem_i[1] ? ob_kalan_q : ob_bolum_q;
    end else if (bitti && !oldur) begin
      sonuc_q <= kalan_sec_q ? bolme_kalan_i : bolme_bolum_i;
    end
  end

  assign sonuc_o         = sonuc_q;
  assign sonuc_gecerli_o = (durum_q == S_DONE) & ~iptal_i;
  assign mesgul_o        = (durum_q != S_IDLE);
  assign bolme_istek_o   = (durum_q == S_ISSUE);
  assign bolme_sign_o    = sign_q;
  assign bolme_bolunen_o = bolunen_q;
  assign bolme_bolen_o   = bolen_q;

endmodule

// File: tb/tb_bolme_denetleyici.sv
// tb_bolme_denetleyici: directed bench; the bench plays the divider
// with hand-computed quotient/remainder values.
module tb_bolme_denetleyici;

  logic        clk;
  logic        rst;
  logic        gecerli;
  logic [1:0]  islem;
  logic [31:0] bolunen;
  logic [31:0] bolen;
  logic        iptal;
  logic [31:0] sonuc;
  logic        sonuc_gecerli;
  logic        mesgul;
  logic        istek;
  logic        sign;
  logic [31:0] d_bolunen;
  logic [31:0] d_bolen;
  logic [31:0] bolum;
  logic [31:0] kalan;
  logic        hazir;

  int n_chk;
  int n_fail;

  bolme_denetleyici dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .islem_gecerli_i (gecerli),
    .islem_i         (islem),
    .bolunen_i       (bolunen),
    .bolen_i         (bolen),
    .iptal_i         (iptal),
    .sonuc_o         (sonuc),
    .sonuc_gecerli_o (sonuc_gecerli),
    .mesgul_o        (mesgul),
    .bolme_istek_o   (istek),
    .bolme_sign_o    (sign),
    .bolme_bolunen_o (d_bolunen),
    .bolme_bolen_o   (d_bolen),
    .bolme_bolum_i   (bolum),
    .bolme_kalan_i   (kalan),
    .bolme_hazir_i   (hazir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Cycle 0 = request presented in IDLE. Miss: istek at 1,
  // hazir at 1+lat, result at 2+lat. Hit: result at 1.
  task automatic do_req(input string tag,
                        input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic hit,
                        input int lat,
                        input logic [31:0] q,
                        input logic [31:0] r,
                        input int kill_c,
                        input logic [31:0] exp);
    int done_c;
    int n_istek;
    int n_pulse;
    int pulse_c;
    logic [31:0] got;
    logic stable;
    logic exp_sign;
    done_c   = hit ? 1 : 2 + lat;
    n_istek  = 0;
    n_pulse  = 0;
    pulse_c  = -1;
    got      = '0;
    stable   = 1'b1;
    exp_sign = ~op[0];
    @(negedge clk);
    gecerli = 1'b1;
    islem   = op;
    bolunen = a;
    bolen   = b;
    iptal   = 1'b0;
    #1;
    if (istek) n_istek++;
    for (int c = 1; c <= done_c + 2; c++) begin
      @(negedge clk);
      if (n_pulse > 0 || (kill_c > 0 && c >= kill_c)) gecerli = 1'b0;
      iptal = (c == kill_c);
      hazir = !hit && (c == 1 + lat);
      bolum = q;
      kalan = r;
      #1;
      if (istek) n_istek++;
      if (!hit && c <= 2 + lat) begin
        if (d_bolunen !== a || d_bolen !== b || sign !== exp_sign)
          stable = 1'b0;
      end
      if (sonuc_gecerli) begin
        n_pulse++;
        pulse_c = c;
        got = sonuc;
      end
      if (kill_c > 0 && c == 1 + lat)
        check({tag, "_wait_busy"}, 32'(mesgul), 32'd1);
      if (kill_c > 0 && c == 2 + lat)
        check({tag, "_idle_after"}, 32'(mesgul), 32'd0);
    end
    hazir   = 1'b0;
    iptal   = 1'b0;
    gecerli = 1'b0;
    check({tag, "_istek_cnt"}, 32'(n_istek), hit ? 32'd0 : 32'd1);
    if (!hit) check({tag, "_stable"}, 32'(stable), 32'd1);
    if (kill_c > 0) begin
      check({tag, "_no_pulse"}, 32'(n_pulse), 32'd0);
    end else begin
      check({tag, "_pulse_cnt"}, 32'(n_pulse), 32'd1);
      check({tag, "_latency"}, 32'(pulse_c), 32'(done_c));
      check({tag, "_sonuc"}, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst     = 1'b0;
    gecerli = 1'b0;
    islem   = 2'b00;
    bolunen = '0;
    bolen   = '0;
    iptal   = 1'b0;
    bolum   = '0;
    kalan   = '0;
    hazir   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_sonuc", sonuc, 32'd0);
    check("rst_flags", {28'd0, sonuc_gecerli, mesgul, istek, sign}, 32'd0);
    check("rst_bolunen", d_bolunen, 32'd0);
    check("rst_bolen", d_bolen, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_req("div_neg", 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0, 11,
           32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFD);
    do_req("rem_hit", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 0,
           32'h0, 32'h0, 0, 32'hFFFF_FFFF);
    do_req("divu_100_7", 2'b01, 32'd100, 32'd7, 1'b0, 10,
           32'd14, 32'd2, 0, 32'd14);
    do_req("div_100_7", 2'b00, 32'd100, 32'd7, 1'b0, 11,
           32'd14, 32'd2, 0, 32'd14);
    do_req("div_by0", 2'b00, 32'd5, 32'd0, 1'b0, 1,
           32'hFFFF_FFFF, 32'd5, 0, 32'hFFFF_FFFF);
    do_req("remu_by0", 2'b11, 32'd5, 32'd0, 1'b0, 1,
           32'hFFFF_FFFF, 32'd5, 0, 32'd5);
    do_req("rem_kill", 2'b10, 32'd100, 32'd7, 1'b0, 11,
           32'd14, 32'd2, 3, 32'd0);
    do_req("rem_after_kill", 2'b10, 32'd100, 32'd7, 1'b1, 0,
           32'h0, 32'h0, 0, 32'd2);

    // Reset while the divider is busy.
    @(negedge clk);
    gecerli = 1'b1;
    islem   = 2'b01;
    bolunen = 32'd9;
    bolen   = 32'd3;
    repeat (3) @(negedge clk);
    #1;
    check("pre_rst_busy", 32'(mesgul), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_flags", {28'd0, sonuc_gecerli, mesgul, istek, sign}, 32'd0);
    check("mid_rst_bolunen", d_bolunen, 32'd0);
    check("mid_rst_bolen", d_bolen, 32'd0);
    check("mid_rst_sonuc", sonuc, 32'd0);
    @(negedge clk);
    gecerli = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    do_req("rem_cache_clr", 2'b10, 32'd100, 32'd7, 1'b0, 11,
           32'd14, 32'd2, 0, 32'd2);
    do_req("divu_9_3", 2'b01, 32'd9, 32'd3, 1'b0, 10,
           32'd3, 32'd0, 0, 32'd3);

    // Stray divider ready in IDLE must be ignored.
    @(negedge clk);
    hazir = 1'b1;
    bolum = 32'hDEAD_BEEF;
    kalan = 32'h1234_5678;
    #1;
    check("stray_idle_pulse", 32'(sonuc_gecerli), 32'd0);
    @(negedge clk);
    hazir = 1'b0;
    #1;
    check("stray_after", {30'd0, sonuc_gecerli, mesgul}, 32'd0);
    check("stray_sonuc", sonuc, 32'd3);
    do_req("divu_9_3_hit", 2'b01, 32'd9, 32'd3, 1'b1, 0,
           32'h0, 32'h0, 0, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
